// File: rtl/alu_mp_sequencer.sv
// Purpose : multi-precision ADD/SUB/SHL/SHR front-end for a combinational 16-bit ALU,
//           streaming one 16-bit word per handshake with the carry chained between words.
// Latency : 1 cycle from input handshake to out_valid; one word per cycle with out_ready high.
// Backpr. : in_ready = !out_valid || out_ready while running; r_word is held while out_ready is low.
// Ports   : clk/rst (async, active-high); start/cmd/len start an operation; busy/done status;
//           in_valid/in_ready/a_word/b_word input stream; out_valid/out_ready/r_word output stream;
//           flags {C,Z,N,V}; alu_a/alu_b/alu_f/alu_cin drive the ALU; alu_result/alu_status come back.
module alu_mp_sequencer #(
   parameter int WORDS = 4,
   parameter int LW    = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [1:0]    cmd,
   input  logic [LW-1:0] len,
   output logic          busy,
   output logic          done,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [15:0]   a_word,
   input  logic [15:0]   b_word,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [15:0]   r_word,
   output logic [3:0]    flags,
   output logic [15:0]   alu_a,
   output logic [15:0]   alu_b,
   output logic [4:0]    alu_f,
   output logic          alu_cin,
   input  logic [15:0]   alu_result,
   input  logic [5:0]    alu_status
);

   localparam logic [1:0] CMD_ADD = 2'd0;
   localparam logic [1:0] CMD_SUB = 2'd1;
   localparam logic [1:0] CMD_SHL = 2'd2;
   localparam logic [1:0] CMD_SHR = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FIN   = 2'd3
   } state_t;

   state_t        r_state;
   logic [1:0]    r_cmd;
   logic [LW-1:0] r_len;
   logic [LW-1:0] r_count;
   logic          r_carry;
   logic          r_zacc;
   logic          r_n_first;   // bit15 of the first result word (MS word for SHR)

   logic [LW-1:0] w_len_clamped;
   logic          w_accept;
   logic          w_first;
   logic          w_last;
   logic          w_res_zero;
   logic          w_n;
   logic          w_v;
   logic          w_unused_status;

   assign w_len_clamped = (len > LW'(WORDS)) ? LW'(WORDS) : len;

   assign in_ready   = (r_state == ST_RUN) && (r_len != '0) && (!out_valid || out_ready);
   assign w_accept   = in_valid && in_ready;
   assign w_first    = (r_count == '0);
   assign w_last     = (r_count == r_len - LW'(1));
   assign w_res_zero = (alu_result == 16'h0000);

   // SHR streams MS word first, so its sign bit arrives with the first word.
   assign w_n = (r_cmd == CMD_SHR) ? (w_first ? alu_result[15] : r_n_first) : alu_result[15];
   assign w_v = (r_cmd == CMD_ADD || r_cmd == CMD_SUB) ? alu_status[2] : 1'b0;

   assign w_unused_status = ^{alu_status[4:3], alu_status[1:0]};

   assign alu_a   = a_word;
   assign alu_b   = b_word;
   assign alu_cin = r_carry;

   // First word uses the carry-less opcode; later words use the carry-chaining variant.
   always_comb begin
      alu_f = 5'b00100;
      case (r_cmd)
         CMD_ADD: alu_f = w_first ? 5'b00100 : 5'b00101;
         CMD_SUB: alu_f = w_first ? 5'b00110 : 5'b00111;
         CMD_SHL: alu_f = w_first ? 5'b10000 : 5'b10110;
         CMD_SHR: alu_f = w_first ? 5'b10001 : 5'b10111;
         default: alu_f = 5'b00100;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_cmd     <= CMD_ADD;
         r_len     <= '0;
         r_count   <= '0;
         r_carry   <= 1'b0;
         r_zacc    <= 1'b0;
         r_n_first <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         out_valid <= 1'b0;
         r_word    <= 16'h0000;
         flags     <= 4'b0000;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_cmd     <= cmd;
                  r_len     <= w_len_clamped;
                  r_count   <= '0;
                  r_carry   <= 1'b0;
                  r_zacc    <= 1'b1;
                  r_n_first <= 1'b0;
                  flags     <= 4'b0000;
                  busy      <= 1'b1;
                  r_state   <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (r_len == '0) begin
                  // Empty operand: value is zero, nothing exchanged.
                  flags   <= 4'b0100;
                  done    <= 1'b1;
                  r_state <= ST_FIN;
               end else if (w_accept) begin
                  r_word    <= alu_result;
                  out_valid <= 1'b1;
                  r_carry   <= alu_status[5];
                  r_zacc    <= r_zacc && w_res_zero;
                  r_count   <= r_count + LW'(1);
                  if (w_first) begin
                     r_n_first <= alu_result[15];
                  end
                  if (w_last) begin
                     flags   <= {alu_status[5], r_zacc && w_res_zero, w_n, w_v};
                     r_state <= ST_DRAIN;
                  end
               end else if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            ST_DRAIN: begin
               if (!out_valid || out_ready) begin
                  out_valid <= 1'b0;
                  done      <= 1'b1;
                  r_state   <= ST_FIN;
               end
            end
            ST_FIN: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/alu_mp_sequencer.md
Name: alu_mp_sequencer

Overview:
- Sequential front-end that drives the 16-bit ALU's operand/opcode/carry-in inputs and consumes its Result/Status outputs.
- Executes multi-precision (N x 16-bit) ADD, SUB, shift-left and shift-right by streaming one 16-bit word per handshake.
- Chains the carry through the ALU's ADC/SBB/RCL/RCR opcodes.
- Sits between an operand-stream source/sink and the combinational ALU, and produces whole-operand flags.

Parameters:
WORDS, 4, maximum operand length in 16-bit words (>=1)
LW, 3, width of len port; must hold WORDS (clog2(WORDS+1))

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  reset; asynchronous, active-high
start  input  1  begin operation; sampled only in IDLE
cmd  input  2  0=ADD, 1=SUB, 2=SHL, 3=SHR; latched at start
len  input  LW  word count; latched at start
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse when the operation completes
in_valid  input  1  a_word/b_word valid
in_ready  output  1  sequencer accepts a word this cycle
a_word  input  16  operand A word
b_word  input  16  operand B word (ignored for shifts)
out_valid  output  1  r_word valid
out_ready  input  1  sink accepts r_word
r_word  output  16  registered result word
flags  output  4  {C,Z,N,V}, registered at completion
alu_a  output  16  to ALU A (combinational = a_word)
alu_b  output  16  to ALU B (combinational = b_word)
alu_f  output  5  to ALU F
alu_cin  output  1  to ALU Cin (= carry register)
alu_result  input  16  from ALU Result
alu_status  input  6  from ALU Status; CF=bit5, ZF=4, NF=3, VF=2

Behaviour:
- Reset values: busy=0, done=0, in_ready=0, out_valid=0, r_word=0, flags=0, carry reg=0, word count=0, state=IDLE. Reset mid-operation drops all in-flight words.
- States:
  - IDLE -> RUN on start. Latch cmd and len; clear carry, count and zero-accumulator.
  - len clamped to WORDS. len==0 -> go straight to FIN: flags={0,1,0,0}, no words exchanged.
  - start while not IDLE is ignored.
- RUN:
  - in_ready = !out_valid || out_ready.
  - On in_valid&&in_ready, same edge:
    - r_word <= alu_result; out_valid <= 1.
    - carry <= alu_status[5]; zacc <= zacc && (alu_result==0); count++.
  - If out_ready is high and no new word is accepted, out_valid <= 0.
- Opcode (alu_f), first word (count==0) / subsequent words:
  - ADD: 00100 / 00101
  - SUB: 00110 / 00111
  - SHL: 10000 / 10110
  - SHR: 10001 / 10111
- alu_cin = carry reg.
- Word order:
  - ADD/SUB/SHL: least-significant word first.
  - SHR: most-significant word first; caller's responsibility.
- Last word (count==len-1) accepted -> go to DRAIN and latch flags:
  - C = alu_status[5]. For SUB this is the borrow.
  - Z = zacc && (alu_result==0).
  - N = bit15 of the MS result word: last word for ADD/SUB/SHL, first word for SHR. A register captures the first word's bit15.
  - V = alu_status[2] for ADD/SUB; 0 for shifts.
- DRAIN: in_ready=0; wait until out_valid==0 or out_ready, clearing out_valid, then -> FIN.
- FIN: done=1 for one cycle, busy=0 on next cycle, -> IDLE.
- busy: 1 in RUN/DRAIN/FIN; done and busy both high in FIN.
- flags hold until the next accepted start clears them.
- Throughput: one word per cycle when out_ready is held high. Latency from input handshake to out_valid is 1 cycle.
- No combinational path from out_ready to out_valid. in_ready may depend combinationally on out_ready.

Test Plan:
- ADD len=2, words (A,B)=(FFFF,0001),(0001,0000) -> r_word 0000, 0002; alu_f 00100 then 00101; alu_cin 0 then 1; flags C0 Z0 N0 V0; done one cycle after last output drained.
- SUB len=2, (0000,0001),(0000,0000) -> FFFF, FFFF; alu_f 00110 then 00111; flags C1 Z0 N1 V0.
- SHL len=3, A=8000,8000,8000 -> 0000, 0001, 0001; alu_f 10000,10110,10110; flags C1 Z0 N0 V0. SHR len=2 MS-first A=0001,0000 -> 0000, 8000; flags C0 Z0 N0.
- Backpressure: out_ready low 3 cycles mid-ADD len=4 -> in_ready low, r_word stable, all 4 words delivered in order; ADD 0000+0000 len=4 -> flags Z=1. len=0 -> done 2 cycles after start, flags Z=1 only.
- rst asserted after first word of len=3 ADD -> busy, out_valid, flags, carry all 0 immediately; a subsequent start with len=1 ADD 7FFF+0001 -> 8000, flags N1 V1 C0.
